// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op-code constants, FSM state type and decode helpers for the multicycle ALU
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SLL = 4'd3;
  localparam logic [3:0] OP_SRL = 4'd4;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_t;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL);
  endfunction

endpackage

// File: rtl/alu_shift_iter.sv
// rtl/alu_shift_iter.sv - iterative one-bit-per-cycle shifter with down-counter
module alu_shift_iter
  import alu_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int SHAMT_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               left,
  input  logic [DATA_W-1:0]  data,
  input  logic [SHAMT_W-1:0] amount,
  output logic               done,
  output logic [DATA_W-1:0]  result
);

  logic [DATA_W-1:0]  shreg;
  logic [SHAMT_W-1:0] cnt;
  logic               dir_left;
  logic [DATA_W-1:0]  shreg_next;

  assign shreg_next = dir_left ? (shreg << 1) : (shreg >> 1);

  // done flags the step that retires the last bit, so the caller can
  // capture result on the same edge the counter reaches zero
  assign done   = (cnt == SHAMT_W'(1));
  assign result = shreg_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg    <= '0;
      cnt      <= '0;
      dir_left <= 1'b0;
    end else if (start) begin
      shreg    <= data;
      cnt      <= amount;
      dir_left <= left;
    end else if (cnt != '0) begin
      shreg <= shreg_next;
      cnt   <= cnt - SHAMT_W'(1);
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - ready/valid ALU with single-cycle logic/arith ops and iterative shifts
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int SHAMT_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        alu_control,
  input  logic [DATA_W-1:0] alu_operand_1,
  input  logic [DATA_W-1:0] alu_operand_2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_out,
  output logic              zero_flag,
  output logic              illegal_op
);

  alu_state_t         state;
  logic               accept;
  logic               start_shift;
  logic [SHAMT_W-1:0] shamt;
  logic [DATA_W-1:0]  comb_res;
  logic               comb_illegal;
  logic               shift_done;
  logic [DATA_W-1:0]  shift_res;

  assign in_ready    = rst_n && (state == ST_IDLE);
  assign accept      = in_valid && in_ready;
  assign shamt       = alu_operand_2[SHAMT_W-1:0];
  assign start_shift = accept && is_shift_op(alu_control) && (shamt != '0);

  // Result for everything that completes on the acceptance edge; a shift
  // by zero simply passes operand 1 through
  always_comb begin
    comb_res     = '0;
    comb_illegal = 1'b0;
    case (alu_control)
      OP_AND:  comb_res = alu_operand_1 & alu_operand_2;
      OP_OR:   comb_res = alu_operand_1 | alu_operand_2;
      OP_ADD:  comb_res = alu_operand_1 + alu_operand_2;
      OP_SUB:  comb_res = alu_operand_1 - alu_operand_2;
      OP_SLT:  comb_res = {{(DATA_W-1){1'b0}},
                           ($signed(alu_operand_1) < $signed(alu_operand_2))};
      OP_SLL,
      OP_SRL:  comb_res = alu_operand_1;
      default: comb_illegal = 1'b1;
    endcase
  end

  alu_shift_iter #(
    .DATA_W  (DATA_W),
    .SHAMT_W (SHAMT_W)
  ) u_shift (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start_shift),
    .left   (alu_control == OP_SLL),
    .data   (alu_operand_1),
    .amount (shamt),
    .done   (shift_done),
    .result (shift_res)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      alu_out    <= '0;
      zero_flag  <= 1'b0;
      illegal_op <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_shift) begin
            state <= ST_SHIFT;
          end else if (accept) begin
            state      <= ST_DONE;
            alu_out    <= comb_res;
            zero_flag  <= (comb_res == '0);
            illegal_op <= comb_illegal;
            out_valid  <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (shift_done) begin
            state      <= ST_DONE;
            alu_out    <= shift_res;
            zero_flag  <= (shift_res == '0);
            illegal_op <= 1'b0;
            out_valid  <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
